// File: rtl/mem_responder.sv
// Single-ported word memory serving the core's fetch and data ports.
// Paces the core with a one-cycle cpu_clk_en pulse per instruction slot.
module mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 imem_en,
    input  logic [31:0]          imem_a,
    output logic [31:0]          imem_v,
    input  logic [31:0]          dmem_a,
    input  logic [31:0]          dmem_wdata,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    output logic [31:0]          dmem_rdata,
    output logic                 cpu_clk_en,
    input  logic                 ld_en,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [31:0]          ld_data,
    output logic [1:0]           err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IFETCH  = 2'd1;
    localparam logic [1:0] S_DACCESS = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] WLAST = 4'(WAIT_STATES);

    logic [31:0] mem [2**ADDR_BITS];

    logic [1:0]           state;
    logic [3:0]           wcnt;
    logic                 last;
    logic                 i_fault;
    logic                 d_fault;
    logic [ADDR_BITS-1:0] i_idx;
    logic [ADDR_BITS-1:0] d_idx;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [31:0]          mem_wd;

    // Misaligned, or beyond the implemented word range.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) ||
               ((a >> (ADDR_BITS + 2)) != 32'd0);
    endfunction

    assign last    = (wcnt == WLAST);
    assign i_idx   = imem_a[ADDR_BITS+1:2];
    assign d_idx   = dmem_a[ADDR_BITS+1:2];
    assign i_fault = bad_addr(imem_a);
    assign d_fault = bad_addr(dmem_a);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (state == S_IDLE && ld_en) begin
            mem_we = 1'b1;
            mem_wa = ld_addr;
            mem_wd = ld_data;
        end else if (state == S_DACCESS && last &&
                     dmem_write && !d_fault) begin
            mem_we = 1'b1;
            mem_wa = d_idx;
            mem_wd = dmem_wdata;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            wcnt       <= 4'd0;
            imem_v     <= 32'd0;
            dmem_rdata <= 32'd0;
            cpu_clk_en <= 1'b0;
            err        <= 2'b00;
        end else begin
            cpu_clk_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    wcnt <= 4'd0;
                    if (!ld_en && imem_en)
                        state <= S_IFETCH;
                end
                S_IFETCH: begin
                    if (last) begin
                        wcnt  <= 4'd0;
                        state <= S_DACCESS;
                        if (i_fault) begin
                            imem_v <= 32'd0;
                            err[0] <= 1'b1;
                        end else begin
                            imem_v <= mem[i_idx];
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                S_DACCESS: begin
                    if (last) begin
                        wcnt       <= 4'd0;
                        state      <= S_DONE;
                        cpu_clk_en <= 1'b1;
                        if (dmem_write) begin
                            if (d_fault)
                                err[1] <= 1'b1;
                        end else if (dmem_read) begin
                            dmem_rdata <= d_fault ? 32'd0
                                                  : mem[d_idx];
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
